// File: rtl/mc_interp_pkg.sv
// Shared types and defaults for the mc_interp 4x4 motion-compensation block.
package mc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CALC,
    OUT
  } mc_state_e;

  localparam int DEF_BLK   = 4;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_MV_W  = 10;
  localparam int DEF_POS_W = 8;

  // Bilinear accumulator width, rounding constant and normalising shift.
  localparam int ACC_W = 13;
  localparam int RND   = 8;
  localparam int SHIFT = 4;

endpackage

// File: rtl/mc_interp_if.sv
// Command, reference-fetch and prediction-stream bundle for mc_interp.
interface mc_interp_if
  import mc_pkg::*;
#(
  parameter int BLK   = DEF_BLK,
  parameter int PIX_W = DEF_PIX_W,
  parameter int MV_W  = DEF_MV_W,
  parameter int POS_W = DEF_POS_W
);

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [POS_W-1:0]           blk_x;
  logic [POS_W-1:0]           blk_y;
  logic [MV_W-1:0]            mv_x;
  logic [MV_W-1:0]            mv_y;

  logic                       ref_req;
  logic [POS_W-1:0]           ref_x;
  logic [POS_W-1:0]           ref_y;
  logic                       ref_rvalid;
  logic [(BLK+1)*PIX_W-1:0]   ref_rdata;

  logic                       pred_valid;
  logic                       pred_ready;
  logic [BLK*PIX_W-1:0]       pred_row;
  logic                       pred_last;

  modport slave (
    input  cmd_valid, blk_x, blk_y, mv_x, mv_y, ref_rvalid, ref_rdata, pred_ready,
    output cmd_ready, ref_req, ref_x, ref_y, pred_valid, pred_row, pred_last
  );

  modport master (
    output cmd_valid, blk_x, blk_y, mv_x, mv_y, ref_rvalid, ref_rdata, pred_ready,
    input  cmd_ready, ref_req, ref_x, ref_y, pred_valid, pred_row, pred_last
  );

endinterface

// File: rtl/mc_bilin_px.sv
// Combinational single-pixel bilinear interpolator with quarter-pel weights.
module mc_bilin_px
  import mc_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic [PIX_W-1:0] c_i,
  input  logic [PIX_W-1:0] d_i,
  input  logic [1:0]       fx_i,
  input  logic [1:0]       fy_i,
  output logic [PIX_W-1:0] p_o
);

  logic [ACC_W-1:0] wx0, wx1, wy0, wy1, acc;

  always_comb begin
    wx1 = ACC_W'(fx_i);
    wx0 = ACC_W'(4) - wx1;
    wy1 = ACC_W'(fy_i);
    wy0 = ACC_W'(4) - wy1;
    acc = wx0 * wy0 * ACC_W'(a_i) + wx1 * wy0 * ACC_W'(b_i)
        + wx0 * wy1 * ACC_W'(c_i) + wx1 * wy1 * ACC_W'(d_i) + ACC_W'(RND);
    p_o = PIX_W'(acc >> SHIFT);
  end

endmodule

// File: rtl/mc_interp.sv
// Decoder-side 4x4 motion compensation: fetches reference rows, bilinearly interpolates, streams rows.
// Optional MC_INT_SKIP_EN: skip the extra reference row when the clamped vertical fraction is zero.
module mc_interp
  import mc_pkg::*;
#(
  parameter int BLK     = DEF_BLK,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int MV_W    = DEF_MV_W,
  parameter int POS_W   = DEF_POS_W,
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64
) (
  input logic        clk,
  input logic        rst,
  mc_interp_if.slave bus
);

  localparam int CW  = POS_W + MV_W + 1;
  localparam int RW  = (BLK + 1) * PIX_W;
  localparam int OW  = BLK * PIX_W;
  localparam int RCW = $clog2(BLK + 1) + 1;
  localparam logic signed [CW-1:0] XMAX = CW'(FRAME_W - BLK - 1);
  localparam logic signed [CW-1:0] YMAX = CW'(FRAME_H - BLK - 1);
`ifdef MC_INT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  mc_state_e        state_q, state_d;
  logic [POS_W-1:0] ix_q, ix_d, iy_q, iy_d;
  logic [1:0]       fx_q, fx_d, fy_q, fy_d;
  logic [RCW-1:0]   r_q, r_d;
  logic [RW-1:0]    prev_q, prev_d, cur_q, cur_d;
  logic [OW-1:0]    row_q, row_d, px;
  logic             last_q, last_d, skip_q, skip_d;

  logic signed [CW-1:0] mvx_s, mvy_s, ix_s, iy_s;
  logic [POS_W-1:0]     ix_c, iy_c;
  logic [1:0]           fx_c, fy_c;

  // Integer position with arithmetic shift (floor), clamped so the 5x5 window stays in-frame.
  always_comb begin
    mvx_s = $signed({{(POS_W+1){bus.mv_x[MV_W-1]}}, bus.mv_x});
    mvy_s = $signed({{(POS_W+1){bus.mv_y[MV_W-1]}}, bus.mv_y});
    ix_s  = $signed({{(MV_W+1){1'b0}}, bus.blk_x}) + (mvx_s >>> 2);
    iy_s  = $signed({{(MV_W+1){1'b0}}, bus.blk_y}) + (mvy_s >>> 2);
    ix_c  = ix_s[POS_W-1:0];
    fx_c  = bus.mv_x[1:0];
    iy_c  = iy_s[POS_W-1:0];
    fy_c  = bus.mv_y[1:0];
    if (ix_s[CW-1]) begin
      ix_c = '0;
      fx_c = '0;
    end else if (ix_s > XMAX) begin
      ix_c = XMAX[POS_W-1:0];
      fx_c = '0;
    end
    if (iy_s[CW-1]) begin
      iy_c = '0;
      fy_c = '0;
    end else if (iy_s > YMAX) begin
      iy_c = YMAX[POS_W-1:0];
      fy_c = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    r_d     = r_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    row_d   = row_q;
    last_d  = last_q;
    skip_d  = skip_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          ix_d    = ix_c;
          iy_d    = iy_c;
          fx_d    = fx_c;
          fy_d    = fy_c;
          skip_d  = SKIP_EN && (fy_c == 2'd0);
          r_d     = RCW'(skip_d);
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.ref_rvalid) begin
          if (r_q == '0) begin
            prev_d = bus.ref_rdata;
            r_d    = RCW'(1);
          end else begin
            cur_d   = bus.ref_rdata;
            if (skip_q) prev_d = bus.ref_rdata;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        row_d   = px;
        last_d  = (r_q == RCW'(BLK));
        state_d = OUT;
      end
      OUT: begin
        if (bus.pred_ready) begin
          prev_d = cur_q;
          if (last_q) begin
            state_d = IDLE;
          end else begin
            r_d     = r_q + RCW'(1);
            state_d = FETCH;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ix_q    <= '0;
      iy_q    <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      r_q     <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      r_q     <= r_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      row_q   <= row_d;
      last_q  <= last_d;
      skip_q  <= skip_d;
    end
  end

  for (genvar i = 0; i < BLK; i++) begin : g_px
    mc_bilin_px #(.PIX_W(PIX_W)) u_px (
      .a_i  (prev_q[i*PIX_W +: PIX_W]),
      .b_i  (prev_q[(i+1)*PIX_W +: PIX_W]),
      .c_i  (cur_q[i*PIX_W +: PIX_W]),
      .d_i  (cur_q[(i+1)*PIX_W +: PIX_W]),
      .fx_i (fx_q),
      .fy_i (fy_q),
      .p_o  (px[i*PIX_W +: PIX_W])
    );
  end

  // In skip mode r starts at 1 so pred_last still fires at r==BLK; the row offset undoes that.
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.ref_req    = (state_q == FETCH);
  assign bus.ref_x      = (state_q == FETCH) ? ix_q : '0;
  assign bus.ref_y      = (state_q == FETCH) ? POS_W'(iy_q + POS_W'(r_q) - POS_W'(skip_q)) : '0;
  assign bus.pred_valid = (state_q == OUT);
  assign bus.pred_row   = row_q;
  assign bus.pred_last  = last_q;

endmodule

// File: tb/tb_mc_interp.sv
// Directed bench for mc_interp: reference-memory responder plus hand-computed expected rows.
module tb_mc_interp;
  import mc_pkg::*;

  localparam int BLK = DEF_BLK;
  localparam int PW  = DEF_PIX_W;
`ifdef MC_INT_SKIP_EN
  localparam int NREQ_FY0 = BLK;
`else
  localparam int NREQ_FY0 = BLK + 1;
`endif

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;
  int   pat = 0;
  int   nreq = 0;
  int   inject_req = 0;
  int   inject_done = 0;
  int   rx_q[$];
  int   ry_q[$];

  mc_interp_if bus ();

  mc_interp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pix(input int p, input int x, input int y);
    case (p)
      0:       return 8'(x + y);
      1:       return 8'(16 * x);
      2:       return 8'(x % 2);
      default: return (x % 2 == 1) ? 8'd3 : 8'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference memory: answers one request per pulse, one negedge after seeing ref_req.
  initial begin
    bus.ref_rvalid = 1'b0;
    bus.ref_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.ref_rvalid) begin
        bus.ref_rvalid = 1'b0;
      end else if (inject_req != inject_done) begin
        bus.ref_rdata  = '1;
        bus.ref_rvalid = 1'b1;
        inject_done++;
      end else if (rst && bus.ref_req) begin
        for (int i = 0; i <= BLK; i++)
          bus.ref_rdata[i*PW +: PW] = pix(pat, int'(bus.ref_x) + i, int'(bus.ref_y));
        rx_q.push_back(int'(bus.ref_x));
        ry_q.push_back(int'(bus.ref_y));
        nreq++;
        bus.ref_rvalid = 1'b1;
      end
    end
  end

  task automatic send_cmd(input int bx, input int by, input int mx, input int my);
    bus.blk_x     = 8'(bx);
    bus.blk_y     = 8'(by);
    bus.mv_x      = 10'(mx);
    bus.mv_y      = 10'(my);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 60; t++) begin
      if (bus.pred_valid) break;
      @(negedge clk);
    end
  endtask

  task automatic run_block(input string nm, input int bx, input int by, input int mx,
                           input int my, input int p, input logic [31:0] row0,
                           input int rinc, input int ex, input int ey, input int en);
    int          base;
    logic [31:0] er;
    pat = p;
    @(negedge clk);
    chk({nm, "_rdy"}, 64'(bus.cmd_ready), 64'd1);
    base = nreq;
    send_cmd(bx, by, mx, my);
    for (int k = 0; k < BLK; k++) begin
      wait_valid();
      for (int i = 0; i < BLK; i++) er[i*8 +: 8] = row0[i*8 +: 8] + 8'(k * rinc);
      chk($sformatf("%s_vld%0d", nm, k), 64'(bus.pred_valid), 64'd1);
      chk($sformatf("%s_row%0d", nm, k), 64'(bus.pred_row), 64'(er));
      chk($sformatf("%s_last%0d", nm, k), 64'(bus.pred_last), 64'(k == BLK - 1));
      @(negedge clk);
    end
    chk({nm, "_nreq"}, 64'(nreq - base), 64'(en));
    if (nreq > base) begin
      chk({nm, "_refx"}, 64'(rx_q[base]), 64'(ex));
      chk({nm, "_refy0"}, 64'(ry_q[base]), 64'(ey));
      chk({nm, "_refyl"}, 64'(ry_q[nreq-1]), 64'(ey + en - 1));
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.blk_x      = '0;
    bus.blk_y      = '0;
    bus.mv_x       = '0;
    bus.mv_y       = '0;
    bus.pred_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(bus.ref_req), 64'd0);
    chk("rst_valid", 64'(bus.pred_valid), 64'd0);
    chk("rst_row", 64'(bus.pred_row), 64'd0);
    chk("rst_last", 64'(bus.pred_last), 64'd0);
    rst = 1'b1;

    run_block("int",   8,  8,   0,   0, 0, 32'h13121110, 1,  8,  8, NREQ_FY0);
    run_block("half",  8,  8,   2,   2, 1, 32'hB8A89888, 0,  8,  8, BLK + 1);
    run_block("q1",    8,  8,   1,   0, 2, 32'h01000100, 0,  8,  8, NREQ_FY0);
    run_block("q3",    8,  8,   1,   0, 3, 32'h02010201, 0,  8,  8, NREQ_FY0);
    run_block("q13",   8,  8,   1,   3, 0, 32'h14131211, 1,  8,  8, BLK + 1);
    run_block("neg",   8,  8,  -3,  -1, 0, 32'h1211100F, 1,  7,  7, BLK + 1);
    run_block("clo",   0,  0, -12, -12, 0, 32'h03020100, 1,  0,  0, NREQ_FY0);
    run_block("clo_f", 0,  0, -13, -13, 0, 32'h03020100, 1,  0,  0, NREQ_FY0);
    run_block("chi",  62, 62,   0,   0, 0, 32'h79787776, 1, 59, 59, NREQ_FY0);
    run_block("chi_f",62, 62,   2,   2, 0, 32'h79787776, 1, 59, 59, NREQ_FY0);

    // Backpressure: first row must stay put with no fetch issued, then reset mid-block.
    pat            = 0;
    bus.pred_ready = 1'b0;
    @(negedge clk);
    send_cmd(8, 8, 0, 0);
    wait_valid();
    chk("bp_valid", 64'(bus.pred_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_row", 64'(bus.pred_row), 64'h13121110);
      chk("bp_req", 64'(bus.ref_req), 64'd0);
    end
    #2 rst = 1'b0;
    #1;
    chk("mrst_req", 64'(bus.ref_req), 64'd0);
    chk("mrst_refx", 64'(bus.ref_x), 64'd0);
    chk("mrst_refy", 64'(bus.ref_y), 64'd0);
    chk("mrst_valid", 64'(bus.pred_valid), 64'd0);
    chk("mrst_row", 64'(bus.pred_row), 64'd0);
    chk("mrst_last", 64'(bus.pred_last), 64'd0);
    @(negedge clk);
    rst            = 1'b1;
    bus.pred_ready = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 64'(bus.cmd_ready), 64'd1);

    inject_req++;
    repeat (4) @(negedge clk);
    chk("stray_rdy", 64'(bus.cmd_ready), 64'd1);
    chk("stray_req", 64'(bus.ref_req), 64'd0);
    chk("stray_valid", 64'(bus.pred_valid), 64'd0);

    run_block("post",  8,  8,   0,   0, 0, 32'h13121110, 1,  8,  8, NREQ_FY0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
